// File: rtl/edge_qualifier.sv
// edge_qualifier: synchronises one async input, rejects short glitches and emits enabled rise/fall pulses.
// Define EDGE_QUAL_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module edge_qualifier #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int FILT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  input  logic       enb_in,
  output logic       enb,
  output logic       rise,
  output logic       fall,
`ifdef EDGE_QUAL_GLITCH_CNT_EN
  output logic [7:0] glitch_cnt,
`endif
  output logic       sig_q
);

  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

  localparam logic [FILT_W-1:0] STAB_ONE = FILT_W'(1);
  localparam logic [FILT_W-1:0] STAB_END = FILT_W'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  state_t                 state_q, state_d;
  logic [FILT_W-1:0]      stab_q, stab_d, stab_inc;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   enb_q, enb_d;
  logic                   commit_rise, commit_fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign stab_inc = stab_q + STAB_ONE;

  always_comb begin
    state_d     = state_q;
    stab_d      = stab_q;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    case (state_q)
      LOW: begin
        stab_d = '0;
        if (sync) begin
          if (FILT_LEN == 1) begin
            state_d     = HIGH;
            commit_rise = 1'b1;
          end else begin
            state_d = RISE_PEND;
            stab_d  = STAB_ONE;
          end
        end
      end
      RISE_PEND: begin
        if (sync) begin
          // stab counts samples already seen high; commit when this one completes the run
          if (stab_inc == STAB_END) begin
            state_d     = HIGH;
            stab_d      = '0;
            commit_rise = 1'b1;
          end else begin
            stab_d = stab_inc;
          end
        end else begin
          state_d = LOW;
          stab_d  = '0;
        end
      end
      HIGH: begin
        stab_d = '0;
        if (!sync) begin
          if (FILT_LEN == 1) begin
            state_d     = LOW;
            commit_fall = 1'b1;
          end else begin
            state_d = FALL_PEND;
            stab_d  = STAB_ONE;
          end
        end
      end
      FALL_PEND: begin
        if (!sync) begin
          if (stab_inc == STAB_END) begin
            state_d     = LOW;
            stab_d      = '0;
            commit_fall = 1'b1;
          end else begin
            stab_d = stab_inc;
          end
        end else begin
          state_d = HIGH;
          stab_d  = '0;
        end
      end
      default: begin
        state_d = LOW;
        stab_d  = '0;
      end
    endcase
  end

  // The FSM tracks regardless of enable; only the pulses are gated, and never deferred
  always_comb begin
    rise_d = commit_rise & enb_in;
    fall_d = commit_fall & enb_in;
    enb_d  = enb_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= LOW;
      stab_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      enb_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      stab_q  <= stab_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      enb_q   <= enb_d;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign enb   = enb_q;
  assign sig_q = (state_q == HIGH) || (state_q == FALL_PEND);

`ifdef EDGE_QUAL_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic       abort;

  always_comb begin
    abort        = ((state_q == RISE_PEND) && !sync) || ((state_q == FALL_PEND) && sync);
    glitch_cnt_d = glitch_cnt_q;
    if (abort && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: doc/edge_qualifier.md
# edge_qualifier

- Conditions one asynchronous pattern input for the edge counting stage.
- Synchronises the input, rejects glitches shorter than a programmable number of cycles, and tracks a filtered level.
- Emits single-cycle `rise`/`fall` pulses gated by `enb`.
- Sits directly upstream of the edge counter and drives its `rise` and `enb` inputs.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal range 2..4.
- `FILT_LEN`, default 4: consecutive stable samples required to accept a level change; legal range 1..15.
- `FILT_W`, default 4: width of the stability counter; must satisfy FILT_LEN ≤ 2^FILT_W − 1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sig_in` in 1: raw asynchronous pattern input.
- `enb_in` in 1: active-high measurement enable, synchronous to clk.
- `enb` out 1: registered copy of enb_in, delayed 1 cycle; aligns the enable with `rise`.
- `rise` out 1: one-cycle pulse on an accepted 0→1 change while enabled.
- `fall` out 1: one-cycle pulse on an accepted 1→0 change while enabled.
- `sig_q` out 1: filtered level.
- `glitch_cnt` out 8: rejected-glitch count; present only with the macro (see Configuration).

## Operation
- **Synchroniser:** SYNC_STAGES flops in series; the last stage is `sync`. All stages reset to 0.
- **FSM states:**
  - LOW: sig_q=0.
  - RISE_PEND: sig_q=0, candidate high.
  - HIGH: sig_q=1.
  - FALL_PEND: sig_q=1, candidate low.
- **Stability counter `stab`** (FILT_W bits, reset 0).
- **LOW:**
  - sync=1 and FILT_LEN=1: commit to HIGH immediately.
  - sync=1 and FILT_LEN>1: go to RISE_PEND, stab=1.
  - Otherwise stay, stab=0.
- **RISE_PEND:**
  - sync=1: stab+1. When stab+1 == FILT_LEN, commit to HIGH and clear stab.
  - sync=0: return to LOW, stab=0, record a glitch.
- **HIGH and FALL_PEND:** mirror images of LOW and RISE_PEND.
- **Commit:**
  - sig_q toggles on the same edge the state changes.
  - rise (or fall) is registered high for exactly one cycle on that edge, qualified by the current enb_in.
- **Tracking while disabled:**
  - The FSM tracks the input regardless of enb_in, so enabling never creates a spurious edge.
  - A commit while enb_in=0 produces no pulse; it is not queued.
- rise and fall are never high together. Two commits are separated by at least FILT_LEN cycles.
- stab never exceeds FILT_LEN and never wraps.

## Timing
- **Reset values:** sig_q=0, rise=0, fall=0, enb=0, glitch_cnt=0, state LOW.
- **Latency:**
  - sig_in changes and stays stable.
  - The first clk edge that samples the new value is edge 0.
  - rise/fall is high in the cycle after edge SYNC_STAGES+FILT_LEN−1, i.e. latency SYNC_STAGES+FILT_LEN cycles.
  - sig_q changes on the same edge.
- **Glitch rejection:** a pulse on sync shorter than FILT_LEN cycles is rejected. It produces no sig_q change and no pulse.
- **sig_in held high through reset release:** rise follows after the nominal latency, provided enb_in=1 at commit.
- **Reset mid-operation:** all state clears immediately (asynchronous). No pulse is generated on reset assertion or on reset release.
- **enb_in changes in the commit cycle:** the value sampled on the commit edge decides whether the pulse is emitted.

## Configuration
- **Macro:** `EDGE_QUAL_GLITCH_CNT_EN`.
- **Defined:**
  - `glitch_cnt` port exists.
  - It increments by 1 on every RISE_PEND→LOW or FALL_PEND→HIGH abort, whether enabled or not.
  - It saturates at 255.
  - It clears only on reset.
- **Undefined:** the port and its counter logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold rst_n=0 with sig_in=1 → all outputs 0. Release with enb_in=1 and default params → rise high for one cycle 6 cycles after the first sampling edge, and sig_q=1 from that edge onward.
- **Clean pulse:** enb_in=1, sig_in high for 20 cycles then low → exactly one rise, then exactly one fall 20 cycles later. sig_q is high for 20 cycles. No other pulses.
- **Glitch:** sig_in high for 3 cycles (FILT_LEN=4), five times → no rise, sig_q stays 0, glitch_cnt=5 (macro on). At FILT_LEN=1 the same stimulus → 5 rise and 5 fall pulses.
- **Enable gating:** edge committed while enb_in=0, then enb_in=1 → no rise. The next genuine rise is reported. enb follows enb_in by 1 cycle.
- **Saturation:** 300 glitches → glitch_cnt=255 and holds.
- **Async reset mid-RISE_PEND** (stab=2) → state LOW and stab=0 immediately. After release with sig_in still high, rise occurs after the full 6-cycle latency, not earlier.
